// File: rtl/ethernet_arp_transmitter_if.sv
// Request and AXI-Stream transmit signals of the ARP reply transmitter.
// master: the transmitter; slave: the request source and stream sink.
interface ethernet_arp_transmitter_if;
  logic        i_arp_valid;
  logic        o_arp_ready;
  logic [47:0] i_req_SHA;
  logic [31:0] i_req_SPA;
  logic        o_tx_axis_tvalid;
  logic        i_tx_axis_tready;
  logic [63:0] o_tx_axis_tdata;
  logic [7:0]  o_tx_axis_tkeep;
  logic        o_tx_axis_tlast;

  modport master (
    input  i_arp_valid,
    input  i_req_SHA,
    input  i_req_SPA,
    input  i_tx_axis_tready,
    output o_arp_ready,
    output o_tx_axis_tvalid,
    output o_tx_axis_tdata,
    output o_tx_axis_tkeep,
    output o_tx_axis_tlast
  );

  modport slave (
    output i_arp_valid,
    output i_req_SHA,
    output i_req_SPA,
    output i_tx_axis_tready,
    input  o_arp_ready,
    input  o_tx_axis_tvalid,
    input  o_tx_axis_tdata,
    input  o_tx_axis_tkeep,
    input  o_tx_axis_tlast
  );
endinterface

// File: rtl/ethernet_arp_transmitter.sv
// Builds an Ethernet ARP reply frame and streams it as 64-bit AXI-Stream beats.
// Define ARP_TX_PAD_EN to zero-pad the frame to the 60-byte Ethernet minimum.
module ethernet_arp_transmitter #(
  parameter logic [47:0] FPGA_MAC = 48'h211abcdef112,
  parameter logic [31:0] FPGA_IP  = 32'hC0000186
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  ethernet_arp_transmitter_if.master        bus,
  output logic [15:0]                       o_tx_count
);

`ifdef ARP_TX_PAD_EN
  localparam int unsigned FRAME_BYTES = 60;
`else
  localparam int unsigned FRAME_BYTES = 42;
`endif
  localparam int unsigned ARP_BYTES = 42;
  localparam int unsigned ARP_BITS  = ARP_BYTES * 8;
  localparam int unsigned BEATS     = (FRAME_BYTES + 7) / 8;
  localparam logic [2:0]  LAST_BEAT = 3'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      r_state;
  logic [2:0]  r_beat;
  logic [47:0] r_sha;
  logic [31:0] r_spa;
  logic [15:0] r_tx_count;
  logic        r_arp_ready;
  logic        r_tvalid;
  logic [63:0] r_tdata;
  logic [7:0]  r_tkeep;
  logic        r_tlast;
  logic [2:0]  w_next_beat;

  assign w_next_beat = r_beat + 3'd1;

  // Eight frame bytes of one beat; bytes past the ARP payload are zero.
  function automatic logic [63:0] beat_data(input logic [2:0]  beat,
                                            input logic [47:0] sha,
                                            input logic [31:0] spa);
    logic [ARP_BITS-1:0] frame;
    logic [ARP_BITS-1:0] shifted;
    logic [5:0]          n;
    frame = {sha, FPGA_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
             16'h0002, FPGA_MAC, FPGA_IP, sha, spa};
    beat_data = '0;
    for (int k = 0; k < 8; k++) begin
      n = {beat, 3'(k)};
      if (32'(n) < ARP_BYTES) begin
        shifted = frame << {n, 3'b000};
        beat_data[8*k +: 8] = shifted[ARP_BITS-1 -: 8];
      end
    end
  endfunction

  function automatic logic [7:0] beat_keep(input logic [2:0] beat);
    logic [5:0] n;
    beat_keep = '0;
    for (int k = 0; k < 8; k++) begin
      n = {beat, 3'(k)};
      beat_keep[k] = (32'(n) < FRAME_BYTES);
    end
  endfunction

  // Request capture, beat sequencing and frame counting.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_sha       <= '0;
      r_spa       <= '0;
      r_tx_count  <= '0;
      r_arp_ready <= 1'b1;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_arp_valid) begin
            r_sha       <= bus.i_req_SHA;
            r_spa       <= bus.i_req_SPA;
            r_beat      <= '0;
            r_state     <= SEND;
            r_arp_ready <= 1'b0;
            r_tvalid    <= 1'b1;
            r_tdata     <= beat_data(3'd0, bus.i_req_SHA, bus.i_req_SPA);
            r_tkeep     <= beat_keep(3'd0);
            r_tlast     <= (LAST_BEAT == 3'd0);
          end
        end
        SEND: begin
          if (r_tvalid && bus.i_tx_axis_tready) begin
            if (r_tlast) begin
              r_state     <= IDLE;
              r_beat      <= '0;
              r_arp_ready <= 1'b1;
              r_tvalid    <= 1'b0;
              r_tdata     <= '0;
              r_tkeep     <= '0;
              r_tlast     <= 1'b0;
              r_tx_count  <= r_tx_count + 16'd1;
            end else begin
              r_beat  <= w_next_beat;
              r_tdata <= beat_data(w_next_beat, r_sha, r_spa);
              r_tkeep <= beat_keep(w_next_beat);
              r_tlast <= (w_next_beat == LAST_BEAT);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_arp_ready      = r_arp_ready;
  assign bus.o_tx_axis_tvalid = r_tvalid;
  assign bus.o_tx_axis_tdata  = r_tdata;
  assign bus.o_tx_axis_tkeep  = r_tkeep;
  assign bus.o_tx_axis_tlast  = r_tlast;
  assign o_tx_count           = r_tx_count;

endmodule

// File: tb/tb_ethernet_arp_transmitter.sv
// Directed bench for ethernet_arp_transmitter: frame content, backpressure,
// back-to-back requests, mid-frame reset and frame counter wrap.
module tb_ethernet_arp_transmitter;

`ifdef ARP_TX_PAD_EN
  localparam int        FRAME_BYTES = 60;
  localparam logic [7:0] LAST_KEEP  = 8'h0F;
`else
  localparam int        FRAME_BYTES = 42;
  localparam logic [7:0] LAST_KEEP  = 8'h03;
`endif
  localparam int          BEATS = (FRAME_BYTES + 7) / 8;
  localparam logic [47:0] MAC   = 48'h211abcdef112;
  localparam logic [31:0] IP    = 32'hC0000186;

  logic        clk;
  logic        rst_n;
  logic [15:0] tx_count;
  int          n_cmp;
  int          n_err;

  logic [63:0] cap_d [16];
  logic [7:0]  cap_k [16];
  logic        cap_l [16];

  ethernet_arp_transmitter_if bus ();

  ethernet_arp_transmitter #(.FPGA_MAC(MAC), .FPGA_IP(IP)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .bus        (bus),
    .o_tx_count (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_beat(input logic [47:0] sha, input logic [31:0] spa, input int b);
    logic [7:0] by [64];
    for (int i = 0; i < 64; i++) by[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      by[i]      = sha[47-8*i -: 8];
      by[6 + i]  = MAC[47-8*i -: 8];
      by[22 + i] = MAC[47-8*i -: 8];
      by[32 + i] = sha[47-8*i -: 8];
    end
    by[12] = 8'h08; by[13] = 8'h06; by[14] = 8'h00; by[15] = 8'h01;
    by[16] = 8'h08; by[17] = 8'h00; by[18] = 8'h06; by[19] = 8'h04;
    by[20] = 8'h00; by[21] = 8'h02;
    for (int i = 0; i < 4; i++) begin
      by[28 + i] = IP[31-8*i -: 8];
      by[38 + i] = spa[31-8*i -: 8];
    end
    exp_beat = '0;
    for (int k = 0; k < 8; k++) exp_beat[8*k +: 8] = by[8*b + k];
  endfunction

  function automatic logic [7:0] exp_keep(input int b);
    exp_keep = '0;
    for (int k = 0; k < 8; k++) exp_keep[k] = ((8*b + k) < FRAME_BYTES);
  endfunction

  task automatic issue(input logic [47:0] sha, input logic [31:0] spa);
    @(negedge clk);
    bus.i_arp_valid = 1'b1;
    bus.i_req_SHA   = sha;
    bus.i_req_SPA   = spa;
  endtask

  // Observes one frame at negedges, optionally stalling beat stall_at for stall_len cycles.
  task automatic capture(input int stall_at, input int stall_len, input bit hold,
                         input logic [47:0] new_sha, output int n, output int cyc,
                         output int first_t, output bit to, output bit held_bad,
                         output bit ready_bad);
    logic [63:0] hd;
    logic [7:0]  hk;
    logic        hl;
    int          stall;
    n = 0; cyc = 0; first_t = -1; to = 1'b1; held_bad = 1'b0; ready_bad = 1'b0;
    stall = 0; hd = '0; hk = '0; hl = 1'b0;
    bus.i_tx_axis_tready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.o_tx_axis_tvalid) begin
        if (first_t < 0) begin
          first_t = t;
          if (!hold) bus.i_arp_valid = 1'b0;
        end
        cyc++;
        if (bus.o_arp_ready !== 1'b0) ready_bad = 1'b1;
        if (hold && n == 1) bus.i_req_SHA = new_sha;
        if (n == stall_at && stall < stall_len) begin
          if (stall == 0) begin
            hd = bus.o_tx_axis_tdata; hk = bus.o_tx_axis_tkeep; hl = bus.o_tx_axis_tlast;
          end else if (bus.o_tx_axis_tdata !== hd || bus.o_tx_axis_tkeep !== hk ||
                       bus.o_tx_axis_tlast !== hl) begin
            held_bad = 1'b1;
          end
          stall++;
          bus.i_tx_axis_tready = 1'b0;
        end else begin
          if (stall > 0 && n == stall_at &&
              (bus.o_tx_axis_tdata !== hd || bus.o_tx_axis_tkeep !== hk ||
               bus.o_tx_axis_tlast !== hl)) held_bad = 1'b1;
          bus.i_tx_axis_tready = 1'b1;
          if (n < 16) begin
            cap_d[n] = bus.o_tx_axis_tdata;
            cap_k[n] = bus.o_tx_axis_tkeep;
            cap_l[n] = bus.o_tx_axis_tlast;
          end
          n++;
          if (bus.o_tx_axis_tlast || n >= 16) begin
            to = !bus.o_tx_axis_tlast;
            break;
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.i_arp_valid = 1'b0;
    bus.i_req_SHA = '0;
    bus.i_req_SPA = '0;
    bus.i_tx_axis_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.o_arp_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.o_arp_ready); end
    n_cmp++; if (bus.o_tx_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", bus.o_tx_axis_tvalid); end
    n_cmp++; if (bus.o_tx_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", bus.o_tx_axis_tlast); end
    n_cmp++; if (bus.o_tx_axis_tkeep !== 8'h00) begin n_err++; $display("FAIL reset_tkeep: got %h want 00", bus.o_tx_axis_tkeep); end
    n_cmp++; if (bus.o_tx_axis_tdata !== 64'h0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", bus.o_tx_axis_tdata); end
    n_cmp++; if (tx_count !== 16'h0000) begin n_err++; $display("FAIL reset_count: got %h want 0000", tx_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame;
    int n, cyc, ft; bit to, hb, rb;
    issue(48'h0a0b0c0d0e0f, 32'hC0000101);
    capture(-1, 0, 1'b0, '0, n, cyc, ft, to, hb, rb);
    n_cmp++; if (to) begin n_err++; $display("FAIL basic_timeout: got no tlast want tlast"); end
    n_cmp++; if (n !== BEATS) begin n_err++; $display("FAIL basic_beats: got %0d want %0d", n, BEATS); end
    n_cmp++; if (cap_d[0] !== 64'h1a210f0e0d0c0b0a) begin n_err++; $display("FAIL basic_beat0: got %h want 1a210f0e0d0c0b0a", cap_d[0]); end
    n_cmp++; if (cap_d[1] !== 64'h0100060812f1debc) begin n_err++; $display("FAIL basic_beat1: got %h want 0100060812f1debc", cap_d[1]); end
    for (int b = 0; b < BEATS && b < n; b++) begin
      n_cmp++;
      if (cap_d[b] !== exp_beat(48'h0a0b0c0d0e0f, 32'hC0000101, b) || cap_k[b] !== exp_keep(b) ||
          cap_l[b] !== (b == BEATS - 1)) begin
        n_err++;
        $display("FAIL basic_beat%0d: got d=%h k=%h l=%b want d=%h k=%h l=%b", b, cap_d[b], cap_k[b],
                 cap_l[b], exp_beat(48'h0a0b0c0d0e0f, 32'hC0000101, b), exp_keep(b), (b == BEATS - 1));
      end
    end
    n_cmp++; if (cap_k[BEATS-1] !== LAST_KEEP) begin n_err++; $display("FAIL basic_last_keep: got %h want %h", cap_k[BEATS-1], LAST_KEEP); end
    n_cmp++; if (rb) begin n_err++; $display("FAIL basic_ready_in_send: got 1 want 0"); end
    @(negedge clk);
    n_cmp++; if (tx_count !== 16'd1) begin n_err++; $display("FAIL basic_count: got %0d want 1", tx_count); end
    n_cmp++; if (bus.o_tx_axis_tvalid !== 1'b0 || bus.o_arp_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_idle: got v=%b r=%b want v=0 r=1", bus.o_tx_axis_tvalid, bus.o_arp_ready);
    end
  endtask

  task automatic test_backpressure;
    int n, cyc, ft; bit to, hb, rb;
    issue(48'h112233445566, 32'h0A000002);
    capture(2, 3, 1'b0, '0, n, cyc, ft, to, hb, rb);
    n_cmp++; if (to || n !== BEATS) begin n_err++; $display("FAIL bp_beats: got %0d to=%b want %0d", n, to, BEATS); end
    n_cmp++; if (hb) begin n_err++; $display("FAIL bp_hold: got changed want stable beat2"); end
    n_cmp++; if (cyc !== BEATS + 3) begin n_err++; $display("FAIL bp_span: got %0d want %0d", cyc, BEATS + 3); end
    n_cmp++; if (cap_d[2] !== exp_beat(48'h112233445566, 32'h0A000002, 2)) begin
      n_err++; $display("FAIL bp_beat2: got %h want %h", cap_d[2], exp_beat(48'h112233445566, 32'h0A000002, 2));
    end
    n_cmp++; if (cap_d[BEATS-1] !== exp_beat(48'h112233445566, 32'h0A000002, BEATS - 1)) begin
      n_err++; $display("FAIL bp_last: got %h want %h", cap_d[BEATS-1], exp_beat(48'h112233445566, 32'h0A000002, BEATS - 1));
    end
    @(negedge clk);
    n_cmp++; if (tx_count !== 16'd2) begin n_err++; $display("FAIL bp_count: got %0d want 2", tx_count); end
  endtask

  task automatic test_back_to_back;
    int n, cyc, ft; bit to, hb, rb;
    logic [47:0] sha1, sha2;
    sha1 = 48'hA1A2A3A4A5A6;
    sha2 = 48'hB1B2B3B4B5B6;
    issue(sha1, 32'hC0A80001);
    capture(-1, 0, 1'b1, sha2, n, cyc, ft, to, hb, rb);
    n_cmp++; if (to || n !== BEATS) begin n_err++; $display("FAIL b2b_beats1: got %0d want %0d", n, BEATS); end
    n_cmp++; if (rb) begin n_err++; $display("FAIL b2b_ready1: got 1 want 0"); end
    for (int b = 0; b < BEATS && b < n; b++) begin
      n_cmp++;
      if (cap_d[b] !== exp_beat(sha1, 32'hC0A80001, b)) begin
        n_err++; $display("FAIL b2b_frame1_beat%0d: got %h want %h", b, cap_d[b], exp_beat(sha1, 32'hC0A80001, b));
      end
    end
    @(negedge clk);
    n_cmp++; if (bus.o_tx_axis_tvalid !== 1'b0 || bus.o_arp_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_gap: got v=%b r=%b want v=0 r=1", bus.o_tx_axis_tvalid, bus.o_arp_ready);
    end
    capture(-1, 0, 1'b0, '0, n, cyc, ft, to, hb, rb);
    n_cmp++; if (ft !== 0) begin n_err++; $display("FAIL b2b_start: got %0d want 0", ft); end
    n_cmp++; if (to || n !== BEATS) begin n_err++; $display("FAIL b2b_beats2: got %0d want %0d", n, BEATS); end
    n_cmp++; if (cap_d[0] !== exp_beat(sha2, 32'hC0A80001, 0) || cap_d[4] !== exp_beat(sha2, 32'hC0A80001, 4)) begin
      n_err++; $display("FAIL b2b_frame2: got %h %h want %h %h", cap_d[0], cap_d[4],
                        exp_beat(sha2, 32'hC0A80001, 0), exp_beat(sha2, 32'hC0A80001, 4));
    end
    @(negedge clk);
    n_cmp++; if (tx_count !== 16'd4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", tx_count); end
  endtask

  task automatic test_reset_midframe;
    int n, cyc, ft; bit to, hb, rb, found, seen_last;
    found = 1'b0; seen_last = 1'b0; n = 0;
    issue(48'h0a0b0c0d0e0f, 32'hC0000101);
    bus.i_tx_axis_tready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.o_tx_axis_tvalid) begin
        bus.i_arp_valid = 1'b0;
        if (bus.o_tx_axis_tlast) seen_last = 1'b1;
        if (n == 4) begin rst_n = 1'b0; found = 1'b1; break; end
        n++;
      end
    end
    n_cmp++; if (!found || seen_last) begin n_err++; $display("FAIL rst_reach_beat4: got found=%b last=%b want 1 0", found, seen_last); end
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (bus.o_tx_axis_tvalid !== 1'b0 || bus.o_tx_axis_tlast !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_out: got v=%b l=%b want 0 0", bus.o_tx_axis_tvalid, bus.o_tx_axis_tlast);
    end
    n_cmp++; if (tx_count !== 16'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d want 0", tx_count); end
    n_cmp++; if (bus.o_arp_ready !== 1'b1 || bus.o_tx_axis_tkeep !== 8'h00 || bus.o_tx_axis_tdata !== 64'h0) begin
      n_err++; $display("FAIL rst_mid_idle: got r=%b k=%h d=%h want 1 00 0", bus.o_arp_ready, bus.o_tx_axis_tkeep, bus.o_tx_axis_tdata);
    end
    issue(48'h0a0b0c0d0e0f, 32'hC0000101);
    capture(-1, 0, 1'b0, '0, n, cyc, ft, to, hb, rb);
    n_cmp++; if (to || n !== BEATS || cap_d[1] !== 64'h0100060812f1debc) begin
      n_err++; $display("FAIL rst_after_frame: got n=%0d b1=%h want %0d 0100060812f1debc", n, cap_d[1], BEATS);
    end
    @(negedge clk);
    n_cmp++; if (tx_count !== 16'd1) begin n_err++; $display("FAIL rst_after_count: got %0d want 1", tx_count); end
  endtask

  task automatic test_count_wrap;
    int n, cyc, ft; bit to, hb, rb;
    @(negedge clk);
    force dut.r_tx_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_tx_count;
    n_cmp++; if (tx_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", tx_count); end
    issue(48'h0a0b0c0d0e0f, 32'hC0000101);
    capture(-1, 0, 1'b0, '0, n, cyc, ft, to, hb, rb);
    @(negedge clk);
    n_cmp++; if (to || tx_count !== 16'h0000) begin n_err++; $display("FAIL wrap_count: got %h want 0000", tx_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ethernet_arp_transmitter.md
ETHERNET_ARP_TRANSMITTER -- requirements
Module: ethernet_arp_transmitter

Interface
REQ-001 SHALL have parameter FPGA_MAC, default 48'h211abcdef112: local MAC, used as Ethernet source and ARP SHA.
REQ-002 SHALL have parameter FPGA_IP, default 32'hC0000186: local IP, used as ARP SPA.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous reset, active-low.
REQ-005 SHALL have port i_arp_valid  input  1  reply request pending.
REQ-006 SHALL have port o_arp_ready  output  1  request accepted when i_arp_valid && o_arp_ready.
REQ-007 SHALL have port i_req_SHA  input  48  requester MAC, from the received request.
REQ-008 SHALL have port i_req_SPA  input  32  requester IP, from the received request.
REQ-009 SHALL have port o_tx_axis_tvalid  output  1  beat valid.
REQ-010 SHALL have port i_tx_axis_tready  input  1  sink ready.
REQ-011 SHALL have port o_tx_axis_tdata  output  64  beat data; frame byte 8k+n in bits [8n+7:8n].
REQ-012 SHALL have port o_tx_axis_tkeep  output  8  byte enables, bit n for byte n.
REQ-013 SHALL have port o_tx_axis_tlast  output  1  final beat of frame.
REQ-014 SHALL have port o_tx_count  output  16  frames completed, wraps 16'hFFFF->0.

Function
REQ-015 SHALL implement states IDLE and SEND, with a 3-bit beat counter.
REQ-016 In IDLE, o_arp_ready SHALL be 1 and o_tx_axis_tvalid 0; on acceptance, SHALL register i_req_SHA/i_req_SPA, clear the counter and enter SEND next cycle.
REQ-017 In SEND, o_arp_ready SHALL be 0; requests are never dropped, only stalled.
REQ-018 Frame byte map SHALL be: 0-5 req SHA; 6-11 FPGA_MAC; 12-13 16'h0806; 14-15 16'h0001; 16-17 16'h0800; 18 8'h06; 19 8'h04; 20-21 16'h0002; 22-27 FPGA_MAC; 28-31 FPGA_IP; 32-37 req SHA; 38-41 req SPA. Multi-byte fields are MSB first.
REQ-019 In SEND, o_tx_axis_tvalid SHALL be 1; the counter SHALL advance only when tvalid && tready. tdata/tkeep/tlast SHALL hold stable while tready=0.
REQ-020 Non-last beats SHALL have tkeep 8'hFF; bytes beyond the last valid byte SHALL drive 0.
REQ-021 On the handshake of the tlast beat, SHALL return to IDLE and increment o_tx_count in the same edge.
REQ-022 First beat SHALL be presented the cycle after acceptance; with tready held 1, the frame SHALL occupy back-to-back cycles; minimum request-to-request period is frame beats + 1.
REQ-023 The registered request SHALL not change during SEND, even if i_req_* inputs change.

Reset
REQ-024 When i_reset=0 at a clock edge, SHALL enter IDLE and clear the counter, request registers and o_tx_count; tvalid/tlast/tkeep/tdata SHALL be 0 and o_arp_ready 1 after that edge.
REQ-025 Reset during SEND SHALL abort the frame without asserting tlast; no partial count increment.

Configuration
REQ-026 Macro ARP_TX_PAD_EN defined: frame SHALL be padded with zero bytes 42-59 to 60 bytes: 8 beats, with the last beat at tkeep 8'h0F.
REQ-027 Macro ARP_TX_PAD_EN undefined: frame SHALL be 42 bytes: 6 beats, with the last beat at tkeep 8'h03.

Verification
REQ-028 Setup: SHA=48'h0a0b0c0d0e0f, SPA=32'hC0000101, tready=1. Check: beat0 tdata=64'h1a210f0e0d0c0b0a, beat1=64'h0100060812f1debc, and o_tx_count becomes 1.
REQ-029 Same request with ARP_TX_PAD_EN defined, then undefined. Check: 8 beats with last tkeep 8'h0F, then 6 beats with last tkeep 8'h03, with tlast on exactly one beat each.
REQ-030 Deassert tready for 3 cycles at beat 2. Check: beat 2 outputs are held unchanged throughout, and the total frame spans 11 cycles (padded).
REQ-031 Hold i_arp_valid=1 continuously with new i_req_SHA during SEND. Check: o_arp_ready=0, the frame carries the original SHA, and the second frame starts 1 cycle after the first tlast.
REQ-032 Assert i_reset=0 at beat 4. Check: tvalid=0 the next cycle, no tlast, o_tx_count=0, and a following request produces a complete frame.
REQ-033 Preload o_tx_count to 16'hFFFF via 65535 frames (or force), then send one more frame. Check: o_tx_count wraps to 16'h0000.
